// File: rtl/ft245_device_if.sv
// FT245 device-side controller: bus reads into RX stream and TX stream onto the bus (FT245_RX_SKID_EN: 2-entry rx buffer).
// Latency: RXF_N fall to RD_N low 3 cycles, RD_N low to RX_VALID RD_LOW_CYC; TX handshake to WR rise WR_SETUP_CYC.
// Backpressure: bus reads stall while the rx buffer is full; TX_READY only in IDLE, TXE_N low and tx granted.
module ft245_device_if #(
  parameter int RD_LOW_CYC   = 4,
  parameter int WR_SETUP_CYC = 1,
  parameter int WR_HIGH_CYC  = 4,
  parameter int RECOVER_CYC  = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       FT_RXF_N,
  input  logic       FT_TXE_N,
  output logic       FT_RD_N,
  output logic       FT_WR,
  inout  wire  [7:0] FT_DATA,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  input  logic       RX_READY,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic       BUSY
);

  typedef enum logic [2:0] {
    IDLE,
    RD_STROBE,
    WR_SETUP,
    WR_STROBE,
    WR_HOLD,
    RECOVER
  } state_t;

  localparam logic [7:0] RD_LAST    = 8'(RD_LOW_CYC - 1);
  localparam logic [7:0] SETUP_LAST = 8'(WR_SETUP_CYC - 1);
  localparam logic [7:0] HIGH_LAST  = 8'(WR_HIGH_CYC - 1);
  localparam logic [7:0] REC_LAST   = 8'(RECOVER_CYC - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       rxf_q1, rxf_s;
  logic       txe_q1, txe_s;
  logic       data_oe;
  logic [7:0] data_q;
  logic       rr_tx_last;

  logic       rx_space;
  logic       rx_req, tx_req;
  logic       rx_gnt, tx_fire;
  logic       rx_wr, rx_hs;

  // Flags come from the FT245 clock domain; both idle high.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rxf_q1 <= 1'b1;
      rxf_s  <= 1'b1;
      txe_q1 <= 1'b1;
      txe_s  <= 1'b1;
    end else begin
      rxf_q1 <= FT_RXF_N;
      rxf_s  <= rxf_q1;
      txe_q1 <= FT_TXE_N;
      txe_s  <= txe_q1;
    end
  end

  assign rx_req   = !rxf_s && rx_space;
  assign tx_req   = !txe_s && TX_VALID;
  // rr_tx_last set means tx was served last, so rx wins a tie
  assign rx_gnt   = (state == IDLE) && rx_req && (!tx_req || rr_tx_last);
  assign TX_READY = (state == IDLE) && !txe_s && (!rx_req || !rr_tx_last);
  assign tx_fire  = TX_READY && TX_VALID;
  assign BUSY     = (state != IDLE);
  assign rx_wr    = (state == RD_STROBE) && (cnt == RD_LAST);
  assign rx_hs    = RX_VALID && RX_READY;

  assign FT_DATA  = data_oe ? data_q : 8'hzz;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      FT_RD_N    <= 1'b1;
      FT_WR      <= 1'b0;
      data_oe    <= 1'b0;
      data_q     <= '0;
      rr_tx_last <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (rx_gnt) begin
            state      <= RD_STROBE;
            FT_RD_N    <= 1'b0;
            rr_tx_last <= 1'b0;
          end else if (tx_fire) begin
            state      <= WR_SETUP;
            data_q     <= TX_DATA;
            data_oe    <= 1'b1;
            rr_tx_last <= 1'b1;
          end
        end
        RD_STROBE: begin
          if (cnt == RD_LAST) begin
            FT_RD_N <= 1'b1;
            state   <= RECOVER;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        WR_SETUP: begin
          if (cnt == SETUP_LAST) begin
            FT_WR <= 1'b1;
            state <= WR_STROBE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        WR_STROBE: begin
          if (cnt == HIGH_LAST) begin
            FT_WR <= 1'b0;
            state <= WR_HOLD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        WR_HOLD: begin
          data_oe <= 1'b0;
          state   <= RECOVER;
          cnt     <= '0;
        end
        RECOVER: begin
          // long enough for the synchronisers to reflect the post-strobe flags
          if (cnt == REC_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          FT_RD_N <= 1'b1;
          FT_WR   <= 1'b0;
          data_oe <= 1'b0;
        end
      endcase
    end
  end

`ifdef FT245_RX_SKID_EN
  logic [7:0] rx_mem [2];
  logic       rx_wp, rx_rp;
  logic [1:0] rx_cnt;

  assign rx_space = (rx_cnt != 2'd2) || rx_hs;
  assign RX_VALID = (rx_cnt != 2'd0);
  assign RX_DATA  = rx_mem[rx_rp];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_mem[0] <= '0;
      rx_mem[1] <= '0;
      rx_wp     <= 1'b0;
      rx_rp     <= 1'b0;
      rx_cnt    <= '0;
    end else begin
      if (rx_wr) begin
        rx_mem[rx_wp] <= FT_DATA;
        rx_wp         <= ~rx_wp;
      end
      if (rx_hs) begin
        rx_rp <= ~rx_rp;
      end
      case ({rx_wr, rx_hs})
        2'b10:   rx_cnt <= rx_cnt + 2'd1;
        2'b01:   rx_cnt <= rx_cnt - 2'd1;
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end
`else
  logic       rx_vld;
  logic [7:0] rx_dat;

  assign rx_space = !rx_vld || rx_hs;
  assign RX_VALID = rx_vld;
  assign RX_DATA  = rx_dat;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_vld <= 1'b0;
      rx_dat <= '0;
    end else if (rx_wr) begin
      rx_vld <= 1'b1;
      rx_dat <= FT_DATA;
    end else if (rx_hs) begin
      rx_vld <= 1'b0;
    end
  end
`endif

  a_no_rd_while_driving: assert property (@(posedge CLK) disable iff (RST) !(!FT_RD_N && data_oe));
  a_no_rd_while_wr:      assert property (@(posedge CLK) disable iff (RST) !(!FT_RD_N && FT_WR));

endmodule

// File: tb/tb_ft245_device_if.sv
// Scoreboard bench for ft245_device_if: host FT245 model on the pins, expected bytes queued at stimulus time.
module tb_ft245_device_if;

`ifdef FT245_RX_SKID_EN
  localparam int BP_READS = 2;
`else
  localparam int BP_READS = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ft_txe_n = 1'b1;
  logic       ft_rd_n, ft_wr;
  wire  [7:0] ft_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy;

  // host model: bytes waiting in host_mem[host_idx .. host_cnt-1]
  logic [7:0] host_mem [32];
  int         host_cnt = 0;
  int         host_idx = 0;
  wire        ft_rxf_n = !(host_idx < host_cnt);
  wire  [7:0] host_byte = host_mem[host_idx[4:0]];
  assign ft_data = (!ft_rd_n) ? host_byte : 8'hzz;

  logic [7:0] rx_exp [$];
  logic [7:0] wr_exp [$];
  int         ord_exp [$];
  int         chk_cnt = 0;
  int         err_cnt = 0;
  int         rd_falls = 0;
  int         overlap = 0;
  int         wr_hi = 0;
  logic       rd_q = 1'b1;
  logic       wr_q = 1'b0;

  always #5 clk = ~clk;

  ft245_device_if dut (
    .CLK      (clk),
    .RST      (rst),
    .FT_RXF_N (ft_rxf_n),
    .FT_TXE_N (ft_txe_n),
    .FT_RD_N  (ft_rd_n),
    .FT_WR    (ft_wr),
    .FT_DATA  (ft_data),
    .RX_DATA  (rx_data),
    .RX_VALID (rx_valid),
    .RX_READY (rx_ready),
    .TX_DATA  (tx_data),
    .TX_VALID (tx_valid),
    .TX_READY (tx_ready),
    .BUSY     (busy)
  );

  task automatic chk(input string nm, input int act, input int exp);
    chk_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // monitor: all output-side comparisons happen here, away from the active edge
  always @(negedge clk) begin
    if (rx_valid && rx_ready) begin
      if (rx_exp.size() == 0) begin
        chk_cnt++;
        err_cnt++;
        $display("FAIL rx_unexpected: got %0h, expected no byte", rx_data);
      end else begin
        chk("rx_data", int'(rx_data), int'(rx_exp.pop_front()));
      end
    end
    if (!ft_rd_n && rd_q) begin
      rd_falls++;
      if (ord_exp.size() != 0) chk("order_rd", 0, ord_exp.pop_front());
    end
    if (ft_rd_n && !rd_q) host_idx++;
    if (ft_wr && !wr_q) begin
      if (ord_exp.size() != 0) chk("order_wr", 1, ord_exp.pop_front());
      if (wr_exp.size() != 0) chk("wr_data_at_rise", int'(ft_data), int'(wr_exp[0]));
    end
    if (ft_wr) wr_hi++;
    if (!ft_wr && wr_q) begin
      chk("wr_high_cycles", wr_hi, 4);
      wr_hi = 0;
      if (wr_exp.size() == 0) begin
        chk_cnt++;
        err_cnt++;
        $display("FAIL wr_unexpected: got %0h, expected no write", ft_data);
      end else begin
        chk("wr_data_hold", int'(ft_data), int'(wr_exp.pop_front()));
      end
    end
    if (!ft_rd_n && ft_wr) overlap++;
    rd_q = ft_rd_n;
    wr_q = ft_wr;
  end

  task automatic tx_handshake(output int waited);
    waited = 0;
    while (!tx_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!tx_ready) chk("tx_ready_timeout", int'(tx_ready), 1);
    @(posedge clk);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((rx_exp.size() != 0 || wr_exp.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_pending"}, rx_exp.size() + wr_exp.size(), 0);
    repeat (12) @(negedge clk);
  endtask

  task automatic host_push(input logic [7:0] b, input bit expect_rx);
    host_mem[host_cnt[4:0]] = b;
    host_cnt++;
    if (expect_rx) rx_exp.push_back(b);
  endtask

  initial begin
    int n;
    int m;
    int base;
    int bad;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_rd_n", int'(ft_rd_n), 1);
    chk("rst_wr", int'(ft_wr), 0);
    chk("rst_rx_valid", int'(rx_valid), 0);
    chk("rst_rx_data", int'(rx_data), 0);
    chk("rst_tx_ready", int'(tx_ready), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single read
    base = rd_falls;
    host_push(8'hA5, 1'b1);
    n = 0;
    while (ft_rd_n && n < 20) begin @(negedge clk); n++; end
    chk("rd_latency", n, 3);
    chk("busy_in_read", int'(busy), 1);
    m = 0;
    while (!ft_rd_n && m < 20) begin @(negedge clk); m++; end
    chk("rd_low_cycles", m, 4);
    chk("rx_valid_at_rd_rise", int'(rx_valid), 1);
    @(negedge clk);
    chk("rx_valid_one_cycle", int'(rx_valid), 0);
    repeat (20) @(negedge clk);
    chk("single_read_count", rd_falls - base, 1);
    drain("single_read");

    // single write
    ft_txe_n = 1'b0;
    repeat (3) @(negedge clk);
    tx_data = 8'h3C;
    tx_valid = 1'b1;
    wr_exp.push_back(8'h3C);
    tx_handshake(n);
    @(negedge clk);
    tx_valid = 1'b0;
    chk("wr_setup_driven", int'(ft_data), 8'h3C);
    chk("wr_low_in_setup", int'(ft_wr), 0);
    chk("busy_in_write", int'(busy), 1);
    @(negedge clk);
    chk("wr_rise_after_setup", int'(ft_wr), 1);
    drain("single_write");

    // TXE_N not ready
    ft_txe_n = 1'b1;
    repeat (3) @(negedge clk);
    tx_data = 8'h5A;
    tx_valid = 1'b1;
    wr_exp.push_back(8'h5A);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_ready || ft_wr) bad++;
    end
    chk("txe_high_blocks", bad, 0);
    ft_txe_n = 1'b0;
    n = 0;
    while (!tx_ready && n < 10) begin @(negedge clk); n++; end
    chk("tx_ready_after_txe", n, 2);
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    drain("txe_wait");

    // contention: rx first, then strict alternation
    for (int i = 0; i < 8; i++) ord_exp.push_back(i % 2);
    for (int i = 0; i < 4; i++) host_push(8'h10 + 8'(i), 1'b1);
    n = 0;
    while (ft_rd_n && n < 50) begin @(negedge clk); n++; end
    for (int i = 0; i < 4; i++) begin
      tx_data = 8'h20 + 8'(i);
      tx_valid = 1'b1;
      wr_exp.push_back(tx_data);
      tx_handshake(n);
      @(negedge clk);
    end
    tx_valid = 1'b0;
    drain("contention");
    chk("order_all_seen", ord_exp.size(), 0);

    // rx backpressure
    @(posedge clk);
    #1 rx_ready = 1'b0;
    @(negedge clk);
    base = rd_falls;
    host_push(8'h31, 1'b1);
    host_push(8'h32, 1'b1);
    host_push(8'h33, 1'b1);
    repeat (40) @(negedge clk);
    chk("bp_reads_stalled", rd_falls - base, BP_READS);
    chk("bp_rx_valid_held", int'(rx_valid), 1);
    chk("bp_rx_data_first", int'(rx_data), 8'h31);
    @(posedge clk);
    #1 rx_ready = 1'b1;
    drain("backpressure");
    chk("bp_all_read", rd_falls - base, 3);

    // reset during a read
    base = rd_falls;
    host_push(8'h44, 1'b0);
    n = 0;
    while (ft_rd_n && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_rd_n", int'(ft_rd_n), 1);
    chk("rst_mid_rx_valid", int'(rx_valid), 0);
    chk("rst_mid_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    host_push(8'h55, 1'b1);
    drain("post_reset");
    chk("post_reset_reads", rd_falls - base, 2);

    chk("rd_wr_overlap", overlap, 0);
    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ft245_device_if.md
# ft245_device_if

Device-side controller for the FT245 parallel USB FIFO bus. It is the stage the host FT245 model talks to across the pins: it drains host-to-device bytes (RXF_N/RD_N) into a valid/ready byte stream and pushes device-to-host bytes from a valid/ready stream onto the bus (TXE_N/WR). It owns all FT245 strobe timing, flag synchronisation and direction arbitration for the shared 8-bit data bus.

## Interface
- RD_LOW_CYC, 4: cycles RD_N is held low; data is sampled on the last cycle; minimum 3.
- WR_SETUP_CYC, 1: cycles data is driven before WR rises; minimum 1.
- WR_HIGH_CYC, 4: cycles WR is held high; minimum 3.
- RECOVER_CYC, 4: idle cycles after any strobe before flags are trusted again; minimum 3.
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- FT_RXF_N  in  1  low = FT245 holds a host byte for the device.
- FT_TXE_N  in  1  low = FT245 can accept a byte for the host.
- FT_RD_N  out  1  read strobe, active low.
- FT_WR  out  1  write strobe; FT245 latches data on its falling edge.
- FT_DATA  inout  8  shared bus; driven only in WR_SETUP, WR_STROBE, WR_HOLD.
- RX_DATA  out  8  received byte.
- RX_VALID  out  1  RX_DATA valid; transfer when RX_VALID & RX_READY.
- RX_READY  in  1  downstream accepts RX_DATA.
- TX_DATA  in  8  byte for host.
- TX_VALID  in  1  TX_DATA valid.
- TX_READY  out  1  combinational; transfer when TX_VALID & TX_READY.
- BUSY  out  1  high whenever state is not IDLE.

## Operation
- FT_RXF_N, FT_TXE_N each pass a 2-flop synchroniser (rxf_s, txe_s); FT_DATA is not synchronised (stable by protocol at sample point).
- States: IDLE, RD_STROBE, WR_SETUP, WR_STROBE, WR_HOLD, RECOVER.
- rx_req = !rxf_s & rx buffer has space; tx_req = !txe_s & TX_VALID.
- IDLE: only rx_req -> RD_STROBE; only tx_req -> TX_READY=1, capture TX_DATA, -> WR_SETUP; both -> round-robin: direction not served last wins (after reset rx wins first).
- RD_STROBE: FT_RD_N=0 for RD_LOW_CYC cycles; on final cycle FT_DATA written into rx buffer, FT_RD_N returns 1 -> RECOVER.
- WR_SETUP: drive captured byte for WR_SETUP_CYC cycles -> WR_STROBE: FT_WR=1 for WR_HIGH_CYC cycles -> WR_HOLD: FT_WR=0, data still driven 1 cycle -> RECOVER.
- RECOVER: RECOVER_CYC cycles, no strobes, bus released -> IDLE.
- Rx buffer without skid: single register; RX_VALID set on write, cleared on handshake; space = !RX_VALID or handshake in same cycle.
- TX_READY is 0 outside IDLE and when grant is rx.
- Reset (any time): FT_RD_N=1, FT_WR=0, FT_DATA hi-Z, RX_VALID=0, RX_DATA=0, TX_READY=0, BUSY=0, state IDLE, round-robin -> rx, synchronisers = 1. A reset during WR_STROBE drops WR asynchronously; the FT245 may latch that byte; accepted.

## Timing
- FT_RXF_N falls: FT_RD_N low 3 cycles later (2 sync + 1 IDLE decision), assuming idle and space.
- RD_N falling to RX_VALID: RD_LOW_CYC cycles.
- TX handshake edge to FT_WR rising: WR_SETUP_CYC cycles; FT_WR falling: +WR_HIGH_CYC.
- Minimum read-to-read period: RD_LOW_CYC+RECOVER_CYC+1 (defaults 9 cycles); write-to-write: WR_SETUP_CYC+WR_HIGH_CYC+1+RECOVER_CYC+1 (defaults 11).
- FT_RD_N low and FT_DATA driven are never simultaneous; FT_RD_N and FT_WR never both active.
- Flag deassertion during a strobe is ignored; RECOVER_CYC ≥ 3 guarantees updated synchronised flags before next decision.

## Configuration
- FT245_RX_SKID_EN defined: rx buffer is a 2-entry FIFO; space = count<2; RX_VALID = count!=0; simultaneous write and handshake keep count; reads continue while downstream stalls for one byte.
- Undefined: single-register rx buffer as above; bus reads stall as soon as one byte is unaccepted.

## Test plan
- Single read: FT_RXF_N low with FT_DATA=8'hA5, RX_READY=1 -> FT_RD_N low 4 cycles, RX_DATA=8'hA5, RX_VALID one cycle, FT_RXF_N raised -> no further RD.
- Single write: TX_VALID with 8'h3C, FT_TXE_N low -> FT_DATA=8'h3C driven 1 cycle before FT_WR high 4 cycles, held 1 cycle after fall, then hi-Z.
- Contention: both flags low, TX_VALID held, 4 bytes each way -> strict alternation rd,wr,rd,wr…, no overlap of RD_N low and data drive.
- Backpressure: RX_READY=0, host offers 3 bytes -> 1 read (2 with FT245_RX_SKID_EN) then FT_RD_N stays high; RX_READY=1 -> remaining bytes delivered in order.
- Flag not ready: TX_VALID=1, FT_TXE_N high 20 cycles -> TX_READY=0, FT_WR=0; TXE_N low -> write within 3 cycles.
- Reset mid-read: RST pulsed during RD_STROBE -> FT_RD_N=1 immediately, RX_VALID=0, BUSY=0; after release next read completes normally.
